// File: rtl/fdc_sd_arbiter.sv
// fdc_sd_arbiter: round-robin arbiter between four wd1793 SD block ports and
// the single MiSTer HPS SD block channel. One drive is granted at a time; its
// LBA and rd/wr are forwarded, and ack/buffer strobes are routed back to it.
// Optional watchdog: define FDC_SD_TIMEOUT_EN to abort stalled transfers.
module fdc_sd_arbiter #(
    parameter int unsigned NUM_DRV   = 4,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_DRV-1:0]       drv_rd,
    input  logic [NUM_DRV-1:0]       drv_wr,
    input  logic [NUM_DRV-1:0][31:0] drv_lba,
    input  logic [NUM_DRV-1:0][7:0]  drv_buff_din,
    output logic [NUM_DRV-1:0]       drv_ack,
    output logic [NUM_DRV-1:0]       drv_buff_wr,
    output logic [31:0]              hps_lba,
    output logic                     hps_rd,
    output logic                     hps_wr,
    input  logic                     hps_ack,
    input  logic                     hps_buff_wr,
    output logic [7:0]               hps_buff_din,
    output logic                     busy,
    output logic [1:0]               grant_idx,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           grant_q, grant_d;
    logic [31:0]          lba_q, lba_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [NUM_DRV-1:0]   ack_q, ack_d;
    logic [NUM_DRV-1:0]   req;
    logic                 win_valid;
    logic [1:0]           win_idx;
    logic [1:0]           cand;
    logic                 to_hit;

    assign req = drv_rd | drv_wr;

    // Round-robin pick: scan from rr_ptr upward; lowest offset with a request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef FDC_SD_TIMEOUT_EN
    // Fires on the (2^TIMEOUT_W-1)th clock without an hps_ack edge.
    localparam logic [TIMEOUT_W-1:0] WdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 ack_prev_q;
    logic                 terr_q, terr_d;

    // Watchdog counter next-state: runs in ISSUE/XFER, restarts on any ack edge.
    always_comb begin
        wd_d   = '0;
        to_hit = 1'b0;
        if (state_q == StIssue || state_q == StXfer) begin
            if (hps_ack != ack_prev_q) begin
                wd_d = '0;
            end else if (wd_q == WdLast) begin
                to_hit = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    // Sticky abort flag: set on watchdog expiry, cleared by the next grant.
    always_comb begin
        terr_d = terr_q;
        if (state_q == StIdle && win_valid) begin
            terr_d = 1'b0;
        end else if (to_hit) begin
            terr_d = 1'b1;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wd_q       <= '0;
            ack_prev_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            wd_q       <= wd_d;
            ack_prev_q <= hps_ack;
            terr_q     <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    // No watchdog: ISSUE/XFER wait indefinitely for the HPS.
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        lba_d    = lba_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ack_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    lba_d   = drv_lba[win_idx];
                    // Read has priority when a drive asserts both.
                    rd_d    = drv_rd[win_idx];
                    wr_d    = ~drv_rd[win_idx];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (to_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                end else if (hps_ack) begin
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = StXfer;
                end else if (!req[grant_q]) begin
                    // Drive withdrew before the HPS answered: abort quietly.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StXfer: begin
                // Request changes are ignored here; the transfer runs to completion.
                if (to_hit) begin
                    state_d = StDone;
                end else if (hps_ack) begin
                    ack_d[grant_q] = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                rr_ptr_d = grant_q + 2'd1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and registered-output state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            lba_q    <= 32'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            lba_q    <= lba_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack_q    <= ack_d;
        end
    end

    // Buffer strobe is combinational so a byte arriving with the first ack is not lost.
    always_comb begin
        drv_buff_wr = '0;
        if ((state_q == StIssue || state_q == StXfer) && hps_ack && hps_buff_wr) begin
            drv_buff_wr[grant_q] = 1'b1;
        end
    end

    assign hps_buff_din = drv_buff_din[grant_q];
    assign drv_ack      = ack_q;
    assign hps_lba      = lba_q;
    assign hps_rd       = rd_q;
    assign hps_wr       = wr_q;
    assign grant_idx    = grant_q;
    assign busy         = (state_q != StIdle);

endmodule
